spi_clk_gen: RTL and testbench

//  Upstream SCK engine for the SPI master datapath. Divides clk_i into spi_clk_o and emits

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_clk_div.sv | 20 ++
 rtl/spi_clk_gen.sv | 71 +++++++
 tb/tb_spi_clk_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types, widths and frame-length decode for the SPI clock engine
package spi_pkg;
    localparam int SPI_DIV_WIDTH = 16;
    localparam int SPI_ECNT_WIDTH = 7;
    typedef enum logic [1:0] {DTB8, DTB16, DTB24, DTB32} dtb_e;
    // Two SCK edges per bit, so 16 edges per byte of frame length
    function automatic logic [SPI_ECNT_WIDTH-1:0] dtb2edges(input dtb_e dtb);
        return {3'(dtb) + 3'd1, 4'b0};
    endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: reloadable down-counter that ticks when it reaches zero and reloads
module spi_clk_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             tick_o
);
    logic [WIDTH-1:0] cnt;
    assign tick_o = en_i & (cnt == '0);
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) cnt <= '0;
        else if (load_i) cnt <= val_i;
        else if (en_i) cnt <= tick_o ? val_i : cnt - 1'b1;
    end
endmodule

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCK generator producing 2*bits edges per frame with registered edge strobes
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH  = SPI_DIV_WIDTH,
    parameter int ECNT_WIDTH = SPI_ECNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 st_i,
    input  logic                 cpol_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           dtb_i,
    output logic                 spi_clk_o,
    output logic                 pos_edge_o,
    output logic                 neg_edge_o,
    output logic                 busy_o,
    output logic                 last_o,
    output logic                 done_o
);
    typedef enum logic {IDLE, RUN} state_e;
    state_e state, state_nxt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [ECNT_WIDTH-1:0] edge_cnt;
    logic cpol_lat, accept, run, tick, final_edge;
    always_comb begin
        accept = st_i & en_i & (state == IDLE);
        run = en_i & (state == RUN);
        final_edge = tick & (edge_cnt == ECNT_WIDTH'(1));
        state_nxt = state;
        if (accept) state_nxt = RUN;
        else if (state == RUN && (!en_i || final_edge)) state_nxt = IDLE;
    end
    spi_clk_div #(.WIDTH(DIV_WIDTH)) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (~accept & ~run),
        .load_i (accept),
        .en_i   (run),
        .val_i  (accept ? div_i : div_lat),
        .tick_o (tick)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            div_lat <= '0;
            cpol_lat <= 1'b0;
            edge_cnt <= '0;
            spi_clk_o <= cpol_i;
            pos_edge_o <= 1'b0;
            neg_edge_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state <= state_nxt;
            pos_edge_o <= tick & ~spi_clk_o;
            neg_edge_o <= tick & spi_clk_o;
            done_o <= final_edge;
            if (accept) begin
                div_lat <= div_i;
                cpol_lat <= cpol_i;
                edge_cnt <= ECNT_WIDTH'(dtb2edges(dtb_e'(dtb_i)));
            end else if (!run) edge_cnt <= '0;
            else if (tick) edge_cnt <= edge_cnt - 1'b1;
            // Abort returns SCK to the latched idle level; idle tracks cpol_i
            spi_clk_o <= run ? spi_clk_o ^ tick : (state == RUN ? cpol_lat : cpol_i);
        end
    end
    assign busy_o = (state == RUN);
    assign last_o = busy_o & (edge_cnt <= ECNT_WIDTH'(2));
endmodule

// File: tb/tb_spi_clk_gen.sv
// tb_spi_clk_gen: directed + randomized frames checked cycle by cycle against an arithmetic edge-schedule model
module tb_spi_clk_gen;
    logic clk = 1'b0;
    logic rst, en, st, cpol;
    logic [15:0] div;
    logic [1:0] dtb;
    logic spi_clk, pos_edge, neg_edge, busy, last, done;
    int checks = 0, failures = 0;
    bit active, mc, idle_sck;
    int t0, md, mn, cyc, npos, nneg, ndone, done_rel;

    always #5 clk = ~clk;

    spi_clk_gen dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .st_i(st), .cpol_i(cpol), .div_i(div), .dtb_i(dtb),
        .spi_clk_o(spi_clk), .pos_edge_o(pos_edge), .neg_edge_o(neg_edge),
        .busy_o(busy), .last_o(last), .done_o(done)
    );

    always @(negedge clk) if (cyc > 0) begin
        checks++;
        assert (!(pos_edge === 1'b1 && neg_edge === 1'b1))
        else begin failures++; $error("FAIL both_edges cyc=%0d got pos=%b neg=%b want not both", cyc, pos_edge, neg_edge); end
    end

    // Frame accepted at cycle t0: edge k lands at t0 + div+2 + k*(div+1), k = 0..N-1
    task automatic step();
        int rel, k, tl;
        bit ed, bz, lvl;
        logic [5:0] exp, got;
        exp = {idle_sck, 5'b0};
        bz = 1'b0;
        rel = 0;
        if (active) begin
            rel = cyc - t0;
            tl = md + 2 + (mn - 1) * (md + 1);
            k = (rel < md + 2) ? 0 : (rel - md - 2) / (md + 1) + 1;
            if (k > mn) k = mn;
            ed = rel >= md + 2 && (rel - md - 2) % (md + 1) == 0 && rel <= tl;
            bz = rel < tl;
            lvl = mc ^ k[0];
            exp = {lvl, ed & lvl, ed & ~lvl, bz, bz && (mn - k <= 2), ed && rel == tl};
        end
        got = {spi_clk, pos_edge, neg_edge, busy, last, done};
        checks++;
        assert (got === exp)
        else begin failures++; $error("FAIL outputs cyc=%0d rel=%0d got sck,pos,neg,busy,last,done=%b want %b", cyc, rel, got, exp); end
        npos += int'(pos_edge === 1'b1);
        nneg += int'(neg_edge === 1'b1);
        if (done === 1'b1) begin ndone++; done_rel = rel; end
        if (rst) begin active = 0; idle_sck = cpol; end
        else if (active && bz) begin
            if (!en) begin active = 0; idle_sck = mc; end
        end else if (st && en) begin
            active = 1; t0 = cyc; md = int'(div); mc = cpol; mn = 16 * (int'(dtb) + 1);
        end else begin active = 0; idle_sck = cpol; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        npos = 0; nneg = 0; ndone = 0; done_rel = -1;
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        assert (got == want)
        else begin failures++; $error("FAIL %s got=%0d want=%0d", tag, got, want); end
    endtask

    task automatic start(input bit c, input int d, input int b);
        en = 1; st = 1; cpol = c; div = 16'(d); dtb = 2'(b);
        step();
        st = 0;
    endtask

    initial begin
        rst = 1; en = 0; st = 0; cpol = 0; div = 0; dtb = 0;
        cyc = 0; active = 0; idle_sck = 0;
        clear_counts();
        @(posedge clk);
        #1;
        cyc = 1;
        steps(2);
        cpol = 1;
        steps(2);
        rst = 0;
        steps(2);
        cpol = 0;
        steps(2);

        // div=0, cpol=0, 8 bits
        clear_counts();
        start(0, 0, 0);
        steps(20);
        check_int("t1_pos", npos, 8);
        check_int("t1_neg", nneg, 8);
        check_int("t1_done", ndone, 1);
        check_int("t1_done_cycle", done_rel, 17);

        // div=3, cpol=1, 16 bits
        clear_counts();
        start(1, 3, 1);
        steps(133);
        check_int("t2_pos", npos, 16);
        check_int("t2_neg", nneg, 16);
        check_int("t2_done_cycle", done_rel, 129);

        // 32 bits, div=1, back-to-back restart at the done cycle
        clear_counts();
        start(0, 1, 3);
        steps(128);
        st = 1;
        step();
        st = 0;
        check_int("t3_pos", npos, 32);
        check_int("t3_neg", nneg, 32);
        check_int("t3_done_cycle", done_rel, 129);
        clear_counts();
        div = 5; dtb = 0;
        steps(129);
        check_int("t3b_edges", npos + nneg, 64);
        check_int("t3b_done_cycle", done_rel, 129);
        steps(2);

        // abort after 5 edges, then a fresh frame
        clear_counts();
        start(1, 2, 2);
        steps(16);
        en = 0;
        steps(4);
        check_int("t4_edges", npos + nneg, 5);
        check_int("t4_done", ndone, 0);
        clear_counts();
        start(0, 0, 1);
        steps(36);
        check_int("t4b_edges", npos + nneg, 32);
        check_int("t4b_done_cycle", done_rel, 33);

        // config changes and start pulses while busy are ignored
        clear_counts();
        start(0, 1, 0);
        for (int i = 0; i < 34; i++) begin
            div = 16'($urandom_range(0, 7));
            cpol = 1'($urandom);
            dtb = 2'($urandom);
            st = 1'($urandom);
            step();
        end
        st = 0;
        check_int("t5_edges", npos + nneg, 16);
        check_int("t5_done_cycle", done_rel, 33);
        steps(2);

        // reset mid-frame
        clear_counts();
        start(1, 2, 3);
        steps(10);
        rst = 1;
        step();
        rst = 0;
        steps(3);
        check_int("t6_done", ndone, 0);

        // random frames with random gaps, mid-frame noise and occasional aborts
        for (int f = 0; f < 12; f++) begin
            int d, b, len;
            bit ab;
            d = $urandom_range(0, 5);
            b = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0);
            len = d + 2 + (16 * (b + 1) - 1) * (d + 1);
            clear_counts();
            steps($urandom_range(0, 3));
            start(1'($urandom), d, b);
            for (int i = 0; i < len + 1; i++) begin
                st = 1'($urandom);
                div = 16'($urandom_range(0, 9));
                dtb = 2'($urandom);
                if (ab && i == len / 2) en = 0;
                if (i >= len - 1) st = 0;
                step();
            end
            st = 0; en = 1;
            steps(1);
            check_int("rnd_done", ndone, ab ? 0 : 1);
            if (!ab) check_int("rnd_edges", npos + nneg, 16 * (b + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
